// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_mem_pkg
//  Purpose  : Types and widths shared by the unified-memory port arbiter
//             and its helpers: arbiter states, grant encoding, bus widths.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

    localparam int c_ADDR_W = 16;
    localparam int c_DATA_W = 16;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Which CPU port owns the current memory access
    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

endpackage : cpu_mem_pkg
`default_nettype wire

// File: rtl/mem_arb_wait_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_wait_ctr
//  Purpose  : Loadable 4-bit wait-state down-counter with a zero flag.
//             Load has priority over decrement; decrement stops at zero.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arb_wait_ctr (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] r_count;

    // Counter register: load new wait count, or count down toward zero
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_count <= 4'd0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign zero = (r_count == 4'd0);

endmodule : mem_arb_wait_ctr
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported 16-bit memory between the CPU fetch
//             (IF) and data (DM) ports. One access at a time, fixed wait
//             states, one-cycle ack, per-port stall outputs. DM has priority.
//  Options  : MEM_ARB_STARVE_GUARD_EN - when defined, forces an IF grant after
//             STARVE_LIMIT consecutive DM grants made while IF was waiting.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int WAIT_STATES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                if_req,
    input  logic [c_ADDR_W-1:0] if_addr,
    output logic [c_DATA_W-1:0] if_rdata,
    output logic                if_ack,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [c_ADDR_W-1:0] dm_addr,
    input  logic [c_DATA_W-1:0] dm_wdata,
    output logic [c_DATA_W-1:0] dm_rdata,
    output logic                dm_ack,
    output logic                mem_en,
    output logic                mem_we,
    output logic [c_ADDR_W-1:0] mem_addr,
    output logic [c_DATA_W-1:0] mem_wdata,
    input  logic [c_DATA_W-1:0] mem_rdata,
    output logic                stall_if,
    output logic                stall_dm,
    output logic                busy
);

    // The counter is loaded with WAIT_STATES-1 so that BUSY lasts exactly
    // WAIT_STATES cycles (the zero cycle is the capture cycle).
    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_STATES - 1);

    generate
        if (WAIT_STATES < 1 || WAIT_STATES > 15 ||
            STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_params
            $error("mem_port_arbiter: WAIT_STATES and STARVE_LIMIT must be 1..15");
        end
    endgenerate

    arb_state_t          r_state;
    arb_state_t          w_next;
    grant_t              r_grant;
    logic [c_ADDR_W-1:0] r_addr;
    logic [c_DATA_W-1:0] r_wdata;
    logic                r_we;
    logic [c_DATA_W-1:0] r_if_rdata;
    logic [c_DATA_W-1:0] r_dm_rdata;

    logic w_start;
    logic w_dec;
    logic w_capture;
    logic w_mem_en;
    logic w_if_ack;
    logic w_dm_ack;
    logic w_ctr_zero;
    logic w_pick_dm;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;
    logic       w_force_if;

    // IF has waited through enough DM grants: it wins this arbitration
    assign w_force_if = if_req && (r_starve_cnt == c_STARVE_LIMIT);
    assign w_pick_dm  = dm_req && !w_force_if;

    // Count DM grants that bypassed a waiting fetch; any IF grant or an
    // idle cycle without a fetch request restarts the count.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_starve_cnt <= 4'd0;
        end else if (r_state == IDLE) begin
            if (!if_req) begin
                r_starve_cnt <= 4'd0;
            end else if (w_start) begin
                if (w_pick_dm) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end else begin
                    r_starve_cnt <= 4'd0;
                end
            end
        end
    end
`else
    assign w_pick_dm = dm_req;
`endif

    // Wait-state timer for the access in flight
    mem_arb_wait_ctr u_wait_ctr (
        .Clk      (Clk),
        .Rst      (Rst),
        .load     (w_start),
        .load_val (c_WAIT_LOAD),
        .dec      (w_dec),
        .zero     (w_ctr_zero)
    );

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_dec     = 1'b0;
        w_capture = 1'b0;
        w_mem_en  = 1'b0;
        w_if_ack  = 1'b0;
        w_dm_ack  = 1'b0;
        case (r_state)
            IDLE: begin
                if (if_req || dm_req) begin
                    w_start = 1'b1;
                    w_next  = BUSY;
                end
            end
            BUSY: begin
                w_mem_en = 1'b1;
                if (w_ctr_zero) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            DONE: begin
                w_if_ack = (r_grant == GNT_IF);
                w_dm_ack = (r_grant == GNT_DM);
                w_next   = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Latch the winning request so input changes mid-access are ignored
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_grant <= GNT_IF;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else if (w_start) begin
            if (w_pick_dm) begin
                r_grant <= GNT_DM;
                r_addr  <= dm_addr;
                r_wdata <= dm_wdata;
                r_we    <= dm_we;
            end else begin
                r_grant <= GNT_IF;
                r_addr  <= if_addr;
                r_wdata <= '0;
                r_we    <= 1'b0;
            end
        end
    end

    // Capture read data for the granted port; writes leave rdata untouched
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else if (w_capture && !r_we) begin
            if (r_grant == GNT_DM) begin
                r_dm_rdata <= mem_rdata;
            end else begin
                r_if_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en    = w_mem_en;
    assign mem_we    = w_mem_en & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_ack    = w_if_ack;
    assign dm_ack    = w_dm_ack;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign stall_if  = if_req & ~w_if_ack;
    assign stall_dm  = dm_req & ~w_dm_ack;
    assign busy      = (r_state != IDLE);

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter with
//             WAIT_STATES=2, STARVE_LIMIT=2, backed by a simple memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int WS = 2;
    localparam int SL = 2;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = 16'h0000;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [15:0] dm_addr = 16'h0000;
    logic [15:0] dm_wdata = 16'h0000;
    logic [15:0] dm_rdata;
    logic        dm_ack;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        stall_if;
    logic        stall_dm;
    logic        busy;

    logic [15:0] mem [0:65535];

    int n_vec = 0;
    int n_err = 0;

    // Control bundle: {mem_en, mem_we, busy, if_ack, dm_ack, stall_if, stall_dm}
    logic [6:0] ctl;
    assign ctl = {mem_en, mem_we, busy, if_ack, dm_ack, stall_if, stall_dm};

    mem_port_arbiter #(
        .WAIT_STATES  (WS),
        .STARVE_LIMIT (SL)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_dm  (stall_dm),
        .busy      (busy)
    );

    always #5 Clk = ~Clk;

    // Memory model: combinational read, write on the clock while enabled
    assign mem_rdata = mem[mem_addr];
    always @(posedge Clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Advance until either ack is seen, bounded
    task automatic wait_ack(output bit got, output bit is_dm);
        got   = 1'b0;
        is_dm = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (if_ack || dm_ack) begin
                got   = 1'b1;
                is_dm = dm_ack;
                return;
            end
        end
    endtask

    task automatic test_reset;
        Rst = 1'b1;
        #1 Rst = 1'b0;
        repeat (3) tick();
        n_vec++; if (ctl !== 7'b0000000) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, 7'b0000000); end
        n_vec++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 64'h0) begin n_err++; $display("FAIL reset_data: got %h want %h", {mem_addr, mem_wdata, if_rdata, dm_rdata}, 64'h0); end
        Rst = 1'b1;
        tick();
        n_vec++; if (ctl !== 7'b0000000) begin n_err++; $display("FAIL reset_release_ctl: got %b want %b", ctl, 7'b0000000); end
    endtask

    task automatic test_single_if_read;
        if_addr = 16'h0010;
        if_req  = 1'b1;
        #1;
        n_vec++; if (ctl !== 7'b0000010) begin n_err++; $display("FAIL if_read_c0: got %b want %b", ctl, 7'b0000010); end
        tick();
        n_vec++; if (ctl !== 7'b1010010) begin n_err++; $display("FAIL if_read_c1: got %b want %b", ctl, 7'b1010010); end
        n_vec++; if (mem_addr !== 16'h0010) begin n_err++; $display("FAIL if_read_addr: got %h want %h", mem_addr, 16'h0010); end
        tick();
        n_vec++; if (ctl !== 7'b1010010) begin n_err++; $display("FAIL if_read_c2: got %b want %b", ctl, 7'b1010010); end
        tick();
        n_vec++; if (ctl !== 7'b0011000) begin n_err++; $display("FAIL if_read_c3: got %b want %b", ctl, 7'b0011000); end
        n_vec++; if (if_rdata !== 16'h7000) begin n_err++; $display("FAIL if_read_data: got %h want %h", if_rdata, 16'h7000); end
        if_req = 1'b0;
        tick();
        n_vec++; if (ctl !== 7'b0000000) begin n_err++; $display("FAIL if_read_c4: got %b want %b", ctl, 7'b0000000); end
        n_vec++; if (if_rdata !== 16'h7000) begin n_err++; $display("FAIL if_rdata_hold: got %h want %h", if_rdata, 16'h7000); end
    endtask

    task automatic test_collision;
        if_addr  = 16'h0020;
        if_req   = 1'b1;
        dm_addr  = 16'h0042;
        dm_wdata = 16'hBEEF;
        dm_we    = 1'b1;
        dm_req   = 1'b1;
        tick();
        n_vec++; if (ctl !== 7'b1110011) begin n_err++; $display("FAIL coll_c1: got %b want %b", ctl, 7'b1110011); end
        n_vec++; if ({mem_addr, mem_wdata} !== {16'h0042, 16'hBEEF}) begin n_err++; $display("FAIL coll_dm_bus: got %h want %h", {mem_addr, mem_wdata}, {16'h0042, 16'hBEEF}); end
        dm_addr = 16'h0099;  // changes mid-access must be ignored
        tick();
        n_vec++; if ({ctl, mem_addr} !== {7'b1110011, 16'h0042}) begin n_err++; $display("FAIL coll_c2: got %h want %h", {ctl, mem_addr}, {7'b1110011, 16'h0042}); end
        tick();
        n_vec++; if (ctl !== 7'b0010110) begin n_err++; $display("FAIL coll_dm_ack: got %b want %b", ctl, 7'b0010110); end
        n_vec++; if (dm_rdata !== 16'h0000) begin n_err++; $display("FAIL coll_write_rdata: got %h want %h", dm_rdata, 16'h0000); end
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
        n_vec++; if (ctl !== 7'b0000010) begin n_err++; $display("FAIL coll_c4: got %b want %b", ctl, 7'b0000010); end
        tick();
        n_vec++; if ({ctl, mem_addr} !== {7'b1010010, 16'h0020}) begin n_err++; $display("FAIL coll_if_grant: got %h want %h", {ctl, mem_addr}, {7'b1010010, 16'h0020}); end
        tick();
        tick();
        n_vec++; if (ctl !== 7'b0011000) begin n_err++; $display("FAIL coll_if_ack: got %b want %b", ctl, 7'b0011000); end
        n_vec++; if (if_rdata !== 16'h1234) begin n_err++; $display("FAIL coll_if_data: got %h want %h", if_rdata, 16'h1234); end
        if_req = 1'b0;
        tick();
        n_vec++; if (mem[16'h0042] !== 16'hBEEF) begin n_err++; $display("FAIL coll_mem_write: got %h want %h", mem[16'h0042], 16'hBEEF); end
    endtask

    task automatic test_dm_read_back;
        dm_addr = 16'h0042;
        dm_we   = 1'b0;
        dm_req  = 1'b1;
        tick();
        tick();
        tick();
        n_vec++; if (ctl !== 7'b0010100) begin n_err++; $display("FAIL dm_read_ack: got %b want %b", ctl, 7'b0010100); end
        n_vec++; if (dm_rdata !== 16'hBEEF) begin n_err++; $display("FAIL dm_read_data: got %h want %h", dm_rdata, 16'hBEEF); end
        dm_req = 1'b0;
        tick();
    endtask

    task automatic test_addr_wrap;
        if_addr = 16'hFFFF;
        if_req  = 1'b1;
        tick();
        n_vec++; if (mem_addr !== 16'hFFFF) begin n_err++; $display("FAIL wrap_addr: got %h want %h", mem_addr, 16'hFFFF); end
        tick();
        tick();
        n_vec++; if ({if_ack, if_rdata} !== {1'b1, 16'hA5A5}) begin n_err++; $display("FAIL wrap_data: got %h want %h", {if_ack, if_rdata}, {1'b1, 16'hA5A5}); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation;
        bit          got;
        bit          is_dm;
        bit          exp_dm [4];
        logic [15:0] dm_exp [3];
        int          n_dm;
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_dm = '{1'b1, 1'b1, 1'b0, 1'b1};
`else
        exp_dm = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
        dm_exp = '{16'h4040, 16'h4141, 16'hBEEF};
        n_dm    = 0;
        if_addr = 16'h0030;
        if_req  = 1'b1;
        dm_addr = 16'h0040;
        dm_we   = 1'b0;
        dm_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(got, is_dm);
            n_vec++;
            if (!got || is_dm !== exp_dm[k]) begin
                n_err++;
                $display("FAIL starve_grant%0d: got ack=%b dm=%b want dm=%b", k, got, is_dm, exp_dm[k]);
            end
            if (got && is_dm) begin
                n_vec++; if (dm_rdata !== dm_exp[n_dm]) begin n_err++; $display("FAIL starve_dm_data%0d: got %h want %h", n_dm, dm_rdata, dm_exp[n_dm]); end
                n_dm++;
                dm_addr = dm_addr + 16'h0001;
                if (n_dm == 3) dm_req = 1'b0;
            end else if (got) begin
                n_vec++; if (if_rdata !== 16'h3030) begin n_err++; $display("FAIL starve_if_data: got %h want %h", if_rdata, 16'h3030); end
                if_req = 1'b0;
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL starve_idle: got %b want %b", busy, 1'b0); end
    endtask

    task automatic test_reset_mid_access;
        bit saw_ack;
        dm_addr = 16'h0041;
        dm_we   = 1'b0;
        dm_req  = 1'b1;
        tick();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy: got %b want %b", busy, 1'b1); end
        #2 Rst = 1'b0;
        #1;
        n_vec++; if (ctl !== 7'b0000001) begin n_err++; $display("FAIL rst_mid_ctl: got %b want %b", ctl, 7'b0000001); end
        n_vec++; if ({if_rdata, dm_rdata} !== 32'h0) begin n_err++; $display("FAIL rst_mid_rdata: got %h want %h", {if_rdata, dm_rdata}, 32'h0); end
        dm_req = 1'b0;
        tick();
        tick();
        Rst = 1'b1;
        saw_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (if_ack || dm_ack || busy) saw_ack = 1'b1;
        end
        n_vec++; if (saw_ack !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_ack: got %b want %b", saw_ack, 1'b0); end
        dm_req = 1'b1;
        tick();
        tick();
        n_vec++; if (dm_ack !== 1'b0) begin n_err++; $display("FAIL rst_new_early: got %b want %b", dm_ack, 1'b0); end
        tick();
        n_vec++; if ({dm_ack, dm_rdata} !== {1'b1, 16'h4141}) begin n_err++; $display("FAIL rst_new_ack: got %h want %h", {dm_ack, dm_rdata}, {1'b1, 16'h4141}); end
        dm_req = 1'b0;
        tick();
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        mem[16'h0010] = 16'h7000;
        mem[16'h0020] = 16'h1234;
        mem[16'h0030] = 16'h3030;
        mem[16'h0040] = 16'h4040;
        mem[16'h0041] = 16'h4141;
        mem[16'hFFFF] = 16'hA5A5;

        test_reset();
        test_single_if_read();
        test_collision();
        test_dm_read_back();
        test_addr_wrap();
        test_starvation();
        test_reset_mid_access();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
